// File: rtl/mux_data_collect.sv
// rtl/mux_data_collect.sv - round-robin merge of five AXI-Stream sources into one registered, source-tagged stream
// Optional macro COLLECT_FORCE_SEL_EN adds a sel input that forces which source is granted in IDLE.
module mux_data_collect #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tdata_m1,
  input  logic [DATA_W-1:0] tdata_m2,
  input  logic [DATA_W-1:0] tdata_s1,
  input  logic [DATA_W-1:0] tdata_s2,
  input  logic [DATA_W-1:0] tdata_s3,
  input  logic              tvalid_m1,
  input  logic              tvalid_m2,
  input  logic              tvalid_s1,
  input  logic              tvalid_s2,
  input  logic              tvalid_s3,
  input  logic              tlast_m1,
  input  logic              tlast_m2,
  input  logic              tlast_s1,
  input  logic              tlast_s2,
  input  logic              tlast_s3,
  output logic              tready_m1,
  output logic              tready_m2,
  output logic              tready_s1,
  output logic              tready_s2,
  output logic              tready_s3,
`ifdef COLLECT_FORCE_SEL_EN
  input  logic [2:0]        sel,
`endif
  output logic [DATA_W-1:0] tdata,
  output logic              tvalid,
  output logic              tlast,
  output logic [2:0]        tsrc,
  input  logic              tready,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        r_state;
  logic [2:0]        r_grant;
  logic [2:0]        r_last_grant;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tvalid;
  logic              r_tlast;
  logic [2:0]        r_tsrc;
  logic [CNT_W-1:0]  r_pkt_count;

  logic [4:0]        w_src_valid;
  logic [4:0]        w_src_last;
  logic [4:0]        w_src_ready;
  logic [DATA_W-1:0] w_src_data [5];
  logic [DATA_W-1:0] w_g_data;
  logic              w_g_valid;
  logic              w_g_last;
  logic              w_out_free;
  logic              w_accept;
  logic [2:0]        w_pick;
  logic [3:0]        w_scan;

  // Index 0..4 holds source code 1..5 (m1, m2, s1, s2, s3).
  assign w_src_valid   = {tvalid_s3, tvalid_s2, tvalid_s1, tvalid_m2, tvalid_m1};
  assign w_src_last    = {tlast_s3, tlast_s2, tlast_s1, tlast_m2, tlast_m1};
  assign w_src_data[0] = tdata_m1;
  assign w_src_data[1] = tdata_m2;
  assign w_src_data[2] = tdata_s1;
  assign w_src_data[3] = tdata_s2;
  assign w_src_data[4] = tdata_s3;

  assign w_out_free = !r_tvalid || tready;

  always_comb begin
    w_g_data    = '0;
    w_g_valid   = 1'b0;
    w_g_last    = 1'b0;
    w_src_ready = '0;
    for (int i = 0; i < 5; i++) begin
      if (r_grant == 3'(i + 1)) begin
        w_g_data       = w_src_data[i];
        w_g_valid      = w_src_valid[i];
        w_g_last       = w_src_last[i];
        w_src_ready[i] = (r_state == ST_BUSY) && w_out_free;
      end
    end
  end

  assign w_accept = (r_state == ST_BUSY) && w_out_free && w_g_valid;

  always_comb begin
    w_pick = '0;
    w_scan = '0;
`ifdef COLLECT_FORCE_SEL_EN
    if ((sel >= 3'd1) && (sel <= 3'd5) && w_src_valid[sel - 3'd1]) begin
      w_pick = sel;
    end
`else
    // Scan downward so the closest code after last_grant is the one that sticks.
    for (int k = 5; k >= 1; k--) begin
      w_scan = {1'b0, r_last_grant} + 4'(k);
      if (w_scan > 4'd5) begin
        w_scan = w_scan - 4'd5;
      end
      if (w_src_valid[w_scan[2:0] - 3'd1]) begin
        w_pick = w_scan[2:0];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= 3'd0;
      r_last_grant <= 3'd5;
    end else if (r_state == ST_IDLE) begin
      if (w_pick != 3'd0) begin
        r_grant <= w_pick;
        r_state <= ST_BUSY;
      end
    end else if (w_accept && w_g_last) begin
      r_state      <= ST_IDLE;
      r_last_grant <= r_grant;
      r_grant      <= 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tsrc   <= 3'd0;
    end else if (w_accept) begin
      r_tdata  <= w_g_data;
      r_tvalid <= 1'b1;
      r_tlast  <= w_g_last;
      r_tsrc   <= r_grant;
    end else if (w_out_free) begin
      r_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_count <= '0;
    end else if (r_tvalid && tready && r_tlast) begin
      r_pkt_count <= r_pkt_count + 1'b1;
    end
  end

  assign tready_m1 = w_src_ready[0];
  assign tready_m2 = w_src_ready[1];
  assign tready_s1 = w_src_ready[2];
  assign tready_s2 = w_src_ready[3];
  assign tready_s3 = w_src_ready[4];
  assign tdata     = r_tdata;
  assign tvalid    = r_tvalid;
  assign tlast     = r_tlast;
  assign tsrc      = r_tsrc;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_mux_data_collect.sv
// tb/tb_mux_data_collect.sv - scoreboard bench for mux_data_collect against a packet-level round-robin model
// Optional macro COLLECT_FORCE_SEL_EN enables the sel port and the forced-select scenario.
module tb_mux_data_collect;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] sd [5];
  logic [4:0]        sv;
  logic [4:0]        sl;
  wire  [4:0]        sr;
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic [2:0]        tsrc;
  logic              tready;
  logic [CNT_W-1:0]  pkt_count;
`ifdef COLLECT_FORCE_SEL_EN
  logic [2:0]        sel;
  int                sel_q[$];
  bit                sel_auto = 1'b1;
`endif

  always #5 clk = ~clk;

  mux_data_collect #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .tdata_m1(sd[0]), .tdata_m2(sd[1]), .tdata_s1(sd[2]), .tdata_s2(sd[3]), .tdata_s3(sd[4]),
    .tvalid_m1(sv[0]), .tvalid_m2(sv[1]), .tvalid_s1(sv[2]), .tvalid_s2(sv[3]), .tvalid_s3(sv[4]),
    .tlast_m1(sl[0]), .tlast_m2(sl[1]), .tlast_s1(sl[2]), .tlast_s2(sl[3]), .tlast_s3(sl[4]),
    .tready_m1(sr[0]), .tready_m2(sr[1]), .tready_s1(sr[2]), .tready_s2(sr[3]), .tready_s3(sr[4]),
`ifdef COLLECT_FORCE_SEL_EN
    .sel(sel),
`endif
    .tdata(tdata), .tvalid(tvalid), .tlast(tlast), .tsrc(tsrc), .tready(tready),
    .pkt_count(pkt_count)
  );

  // Source driver queues and the model's own copy of the same packets.
  logic [7:0]  dq [5][$];
  bit          lq [5][$];
  logic [7:0]  mq_d [5][$];
  bit          mq_l [5][$];
  bit          in_pkt [5];
  bit          hs [5];
  logic [11:0] exp_q[$];
  logic [11:0] mon_e;
  int          m_last = 5;
  int          exp_pkts = 0;
  int          checks = 0;
  int          failures = 0;
  bit          gap_en = 1'b0;
  int          rdy_mode = 0;
  logic [7:0]  held;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) hs[i] = sv[i] && sr[i];
    if (rst_n) begin
      check("tready_onehot", 32'($countones(sr) <= 1), 32'd1);
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=0x%0h required=none", {tsrc, tlast, tdata});
        end else begin
          mon_e = exp_q.pop_front();
          check("out_beat", 32'({tsrc, tlast, tdata}), 32'(mon_e));
        end
      end
    end
  end

  task automatic add_pkt(int s, int n, logic [7:0] base, bit rnd);
    for (int b = 0; b < n; b++) begin
      logic [7:0] d;
      bit l;
      d = rnd ? 8'($urandom) : base + 8'(b);
      l = (b == n - 1);
      dq[s].push_back(d);   lq[s].push_back(l);
      mq_d[s].push_back(d); mq_l[s].push_back(l);
    end
  endtask

  task automatic model_take(int src);
    logic [7:0] d;
    bit l;
    l = 1'b0;
    while (!l && mq_d[src-1].size() > 0) begin
      d = mq_d[src-1].pop_front();
      l = mq_l[src-1].pop_front();
      exp_q.push_back({3'(src), l, d});
    end
    m_last = src;
    exp_pkts++;
  endtask

  // Whole-packet round robin: next code after the last winner that still has packets waiting.
  task automatic model_run();
    int pick;
    while (1) begin
      pick = 0;
      for (int k = 1; k <= 5; k++) begin
        int c;
        c = (m_last + k - 1) % 5 + 1;
        if (pick == 0 && mq_d[c-1].size() > 0) pick = c;
      end
      if (pick == 0) break;
`ifdef COLLECT_FORCE_SEL_EN
      sel_q.push_back(pick);
`endif
      model_take(pick);
    end
  endtask

  function automatic bit any_src();
    bit r;
    r = 1'b0;
    for (int i = 0; i < 5; i++) if (dq[i].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < 5; i++) begin
      if (dq[i].size() > 0) begin
        sd[i] = dq[i][0];
        sl[i] = lq[i][0];
        sv[i] = !(in_pkt[i] && gap_en && ($urandom_range(0, 2) == 0));
      end else begin
        sd[i] = '0;
        sl[i] = 1'b0;
        sv[i] = 1'b0;
      end
    end
    case (rdy_mode)
      0:       tready = 1'b1;
      1:       tready = ($urandom_range(0, 3) != 0);
      default: tready = 1'b0;
    endcase
`ifdef COLLECT_FORCE_SEL_EN
    if (sel_auto) sel = (sel_q.size() > 0) ? 3'(sel_q[0]) : 3'd0;
`endif
  endtask

  task automatic cycle();
    bit was;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (hs[i] && dq[i].size() > 0) begin
        was = in_pkt[i];
        in_pkt[i] = !lq[i][0];
        void'(dq[i].pop_front());
        void'(lq[i].pop_front());
`ifdef COLLECT_FORCE_SEL_EN
        if (sel_auto && !was && sel_q.size() > 0) void'(sel_q.pop_front());
`else
        if (was) begin end
`endif
      end
    end
    drive();
  endtask

  task automatic clear_all();
    for (int i = 0; i < 5; i++) begin
      dq[i].delete(); lq[i].delete(); mq_d[i].delete(); mq_l[i].delete();
      in_pkt[i] = 1'b0;
    end
    exp_q.delete();
    m_last = 5;
    exp_pkts = 0;
`ifdef COLLECT_FORCE_SEL_EN
    sel_q.delete();
`endif
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_all();
    drive();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic drain(string name, int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || any_src()) && n < budget) begin
      cycle();
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    if (n >= budget) begin
      for (int i = 0; i < 5; i++) begin dq[i].delete(); lq[i].delete(); in_pkt[i] = 1'b0; end
      exp_q.delete();
    end
    repeat (3) cycle();
    check({name, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkts[CNT_W-1:0]));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 5; i++) begin sd[i] = '0; in_pkt[i] = 1'b0; end
    sv = '0;
    sl = '0;
    tready = 1'b1;
`ifdef COLLECT_FORCE_SEL_EN
    sel = 3'd0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_tsrc", 32'(tsrc), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_treadys", 32'(sr), 32'd0);
    rst_n = 1'b1;
    cycle();

    // s1 three-beat packet: output valid on cycles 2..4 after the source raises tvalid.
    add_pkt(2, 3, 8'hA1, 1'b0);
    model_run();
    drive();
    cycle();
    check("t1_c1_tvalid", 32'(tvalid), 32'd0);
    cycle();
    check("t1_c2_tvalid", 32'(tvalid), 32'd1);
    check("t1_c2_tdata", 32'(tdata), 32'hA1);
    check("t1_c2_tsrc", 32'(tsrc), 32'd3);
    cycle();
    cycle();
    check("t1_c4_beat", 32'({tvalid, tlast, tdata}), 32'h3A3);
    drain("t1", 100);

    // m1 and s3 contend after reset: m1 first, one empty cycle, then s3.
    reset_dut();
    add_pkt(0, 2, 8'h10, 1'b0);
    add_pkt(4, 2, 8'h20, 1'b0);
    model_run();
    drive();
    repeat (3) cycle();
    check("t2_m1_last", 32'({tvalid, tlast, tsrc}), 32'b1_1_001);
    cycle();
    check("t2_idle_gap", 32'(tvalid), 32'd0);
    cycle();
    check("t2_s3_first", 32'({tvalid, tsrc}), 32'b1_101);
    drain("t2", 100);

    // All five sources continuously offering single-beat packets.
    reset_dut();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 5; s++) add_pkt(s, 1, 8'(8'h30 + 8'(r * 8 + s)), 1'b0);
    model_run();
    drive();
    drain("t3", 200);

    // Downstream stall mid-packet.
    add_pkt(3, 4, 8'h40, 1'b0);
    model_run();
    drive();
    repeat (3) cycle();
    rdy_mode = 2;
    tready = 1'b0;
    held = tdata;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("t4_stall_hold", 32'({tvalid, tdata}), 32'({1'b1, held}));
      check("t4_stall_src_rdy", 32'(sr[3]), 32'd0);
    end
    rdy_mode = 0;
    tready = 1'b1;
    drain("t4", 100);

    // Reset asserted in the middle of a four-beat m2 packet.
    add_pkt(1, 4, 8'h50, 1'b0);
    model_run();
    drive();
    repeat (3) cycle();
    rst_n = 1'b0;
    #1;
    check("t5_rst_tvalid", 32'(tvalid), 32'd0);
    check("t5_rst_treadys", 32'(sr), 32'd0);
    check("t5_rst_pkt_count", 32'(pkt_count), 32'd0);
    clear_all();
    drive();
    cycle();
    rst_n = 1'b1;
    for (int s = 0; s < 5; s++) add_pkt(s, 1, 8'(8'h60 + 8'(s)), 1'b0);
    model_run();
    drive();
    cycle();
    cycle();
    check("t5_first_after_rst", 32'({tvalid, tsrc}), 32'b1_001);
    drain("t5", 100);

    // Randomized traffic with source gaps and downstream backpressure.
    gap_en = 1'b1;
    rdy_mode = 1;
    for (int r = 0; r < 20; r++) begin
      for (int s = 0; s < 5; s++)
        if ($urandom_range(0, 1) == 1)
          for (int p = 0; p < $urandom_range(1, 2); p++) add_pkt(s, $urandom_range(1, 4), 8'h00, 1'b1);
      model_run();
      drive();
      drain("rnd", 2000);
    end
    gap_en = 1'b0;
    rdy_mode = 0;

`ifdef COLLECT_FORCE_SEL_EN
    sel_auto = 1'b0;
    sel = 3'd4;
    add_pkt(0, 2, 8'h70, 1'b0);
    add_pkt(3, 2, 8'h80, 1'b0);
    model_take(4);
    drive();
    repeat (12) cycle();
    check("sel4_s2_done", 32'(exp_q.size()), 32'd0);
    check("sel4_m1_waiting", 32'(dq[0].size()), 32'd2);
    sel = 3'd0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      check("sel0_no_grant", 32'({tvalid, sr[0]}), 32'd0);
    end
    sel = 3'd1;
    model_take(1);
    drain("sel1", 100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
